reg_access_arbiter: RTL and testbench

REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

---
 rtl/reg_access_arbiter.sv | 150 +++++++++++++++
 tb/tb_reg_access_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arbiter.sv
// Two-requester round-robin arbiter onto a single register-bank port.
// Define RD_TIMEOUT_EN to compile in the read-response timeout.
module reg_access_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_wr,
  input  logic        m0_rd,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  output logic        m0_err,
  input  logic [15:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_wr,
  input  logic        m1_rd,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [15:0] wr_rd_addr,
  output logic        wr_en,
  output logic        rd_en,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_datain,
  input  logic        rd_dvalid
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CMD     = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;

  logic [1:0]  state;
  logic        op_wr;
  logic        port;
  logic        prio;
  logic [15:0] addr_q;
  logic [31:0] data_q;

  logic p0, p1, gnt1, in_cmd;

  assign p0   = m0_wr | m0_rd;
  assign p1   = m1_wr | m1_rd;
  // prio=1 means m1 wins a tie; a lone requester always wins
  assign gnt1 = p1 & (~p0 | prio);

  assign in_cmd     = (state == CMD);
  assign m0_ready   = in_cmd & ~port;
  assign m1_ready   = in_cmd & port;
  assign wr_en      = in_cmd & op_wr;
  assign rd_en      = in_cmd & ~op_wr;
  assign wr_rd_addr = in_cmd ? addr_q : 16'h0;
  assign wr_data    = wr_en ? data_q : 32'h0;

`ifdef RD_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt;
  logic        m0_err_q, m1_err_q;
  logic        to_hit;

  assign to_hit = (cnt == TO_LAST);
  assign m0_err = m0_err_q;
  assign m1_err = m1_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 16'h0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
    end else begin
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      if (state == CMD) begin
        cnt <= 16'h0;
      end else if (state == RD_WAIT && !rd_dvalid) begin
        if (to_hit) begin
          m0_err_q <= ~port;
          m1_err_q <= port;
        end else begin
          cnt <= cnt + 16'h1;
        end
      end
    end
  end
`else
  logic to_hit;
  logic unused_to;

  assign to_hit    = 1'b0;
  assign unused_to = ^16'(TIMEOUT_CYCLES);
  assign m0_err    = 1'b0;
  assign m1_err    = 1'b0;
`endif

  logic        done;
  logic [31:0] done_data;

  assign done      = (state == RD_WAIT) & (rd_dvalid | to_hit);
  assign done_data = rd_dvalid ? rd_datain : 32'hDEAD_BEEF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      port      <= 1'b0;
      prio      <= 1'b0;
      addr_q    <= 16'h0;
      data_q    <= 32'h0;
      m0_rdata  <= 32'h0;
      m1_rdata  <= 32'h0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (p0 | p1) begin
            state  <= CMD;
            port   <= gnt1;
            prio   <= ~gnt1;
            op_wr  <= gnt1 ? m1_wr : m0_wr;
            addr_q <= gnt1 ? m1_addr : m0_addr;
            data_q <= gnt1 ? m1_wdata : m0_wdata;
          end
        end
        CMD: begin
          state <= op_wr ? IDLE : RD_WAIT;
        end
        RD_WAIT: begin
          if (done) begin
            state <= IDLE;
            if (port) begin
              m1_rdata  <= done_data;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rdata  <= done_data;
              m0_rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed vector bench for reg_access_arbiter.
// Timeout sequences follow the RD_TIMEOUT_EN build of the design.
module tb_reg_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_wr, m0_rd, m1_wr, m1_rd;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rvalid, m1_rvalid;
  logic        m0_err, m1_err;
  logic [15:0] wr_rd_addr;
  logic        wr_en, rd_en;
  logic [31:0] wr_data;
  logic [31:0] rd_datain;
  logic        rd_dvalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_access_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wr(m0_wr), .m0_rd(m0_rd),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m0_rvalid(m0_rvalid), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wr(m1_wr), .m1_rd(m1_rd),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .m1_rvalid(m1_rvalid), .m1_err(m1_err),
    .wr_rd_addr(wr_rd_addr), .wr_en(wr_en), .rd_en(rd_en),
    .wr_data(wr_data), .rd_datain(rd_datain), .rd_dvalid(rd_dvalid)
  );

  typedef struct {
    logic        r;
    logic [3:0]  req;
    logic [15:0] a0, a1;
    logic [31:0] d0, d1;
    logic        dv;
    logic [31:0] din;
    logic [1:0]  rdy;
    logic        wen, ren;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [1:0]  rv;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic r, input logic [3:0] req,
    input logic [15:0] a0, input logic [31:0] d0,
    input logic [15:0] a1, input logic [31:0] d1,
    input logic dv, input logic [31:0] din,
    input logic [1:0] rdy, input logic wen, input logic ren,
    input logic [15:0] addr, input logic [31:0] wd,
    input logic [1:0] rv, input logic [31:0] rd0,
    input logic [31:0] rd1);
    vec_t v;
    v.r = r; v.req = req; v.a0 = a0; v.d0 = d0;
    v.a1 = a1; v.d1 = d1; v.dv = dv; v.din = din;
    v.rdy = rdy; v.wen = wen; v.ren = ren;
    v.addr = addr; v.wd = wd; v.rv = rv;
    v.rd0 = rd0; v.rd1 = rd1;
    vq.push_back(v);
  endtask

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    rst = 1'b0;
    m0_wr = 1'b0; m0_rd = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0;
    m0_addr = 16'h0; m1_addr = 16'h0;
    m0_wdata = 32'h0; m1_wdata = 32'h0;
    rd_dvalid = 1'b0; rd_datain = 32'h0;
  endtask

  logic [31:0] cf, bd, z;
  logic [127:0] act_v, exp_v;
  int n;
  logic early;

  initial begin
    cf = 32'hCAFE_F00D;
    bd = 32'h0BAD_F00D;
    z  = 32'h0;
    idle_in();
    rst = 1'b1;

    // r req a0 d0 a1 d1 dv din | rdy wen ren addr wd rv rd0 rd1
    add(1, 4'b0000, 16'h0, z, 16'h0, z, 0, z,
        2'b00, 0, 0, 16'h0, z, 2'b00, z, z);
    add(0, 4'b0001, 16'h0010, 32'h1234_5678, 16'h0, z, 0, z,
        2'b01, 1, 0, 16'h0010, 32'h1234_5678, 2'b00, z, z);
    add(0, 4'b0001, 16'h0010, 32'h1234_5678, 16'h0, z, 0, z,
        2'b00, 0, 0, 16'h0, z, 2'b00, z, z);
    add(0, 4'b1000, 16'h0, z, 16'h0020, z, 0, z,
        2'b10, 0, 1, 16'h0020, z, 2'b00, z, z);
    add(0, 4'b1000, 16'h0, z, 16'h0020, z, 0, z,
        2'b00, 0, 0, 16'h0, z, 2'b00, z, z);
    add(0, 4'b0000, 16'h0, z, 16'h0, z, 0, z,
        2'b00, 0, 0, 16'h0, z, 2'b00, z, z);
    add(0, 4'b0000, 16'h0, z, 16'h0, z, 0, z,
        2'b00, 0, 0, 16'h0, z, 2'b00, z, z);
    add(0, 4'b0000, 16'h0, z, 16'h0, z, 1, cf,
        2'b00, 0, 0, 16'h0, z, 2'b10, z, cf);
    add(0, 4'b0000, 16'h0, z, 16'h0, z, 1, 32'h1111_1111,
        2'b00, 0, 0, 16'h0, z, 2'b00, z, cf);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        add(0, 4'b0101, 16'h0100, 32'hAAAA_0000,
            16'h0200, 32'hBBBB_1111, 0, z,
            2'b01, 1, 0, 16'h0100, 32'hAAAA_0000, 2'b00, z, cf);
      else
        add(0, 4'b0101, 16'h0100, 32'hAAAA_0000,
            16'h0200, 32'hBBBB_1111, 0, z,
            2'b10, 1, 0, 16'h0200, 32'hBBBB_1111, 2'b00, z, cf);
      add(0, (k == 3) ? 4'b0000 : 4'b0101, 16'h0100, 32'hAAAA_0000,
          16'h0200, 32'hBBBB_1111, 0, z,
          2'b00, 0, 0, 16'h0, z, 2'b00, z, cf);
    end
    add(0, 4'b0011, 16'h0030, 32'h5555_AAAA, 16'h0, z, 0, z,
        2'b01, 1, 0, 16'h0030, 32'h5555_AAAA, 2'b00, z, cf);
    add(0, 4'b0011, 16'h0030, 32'h5555_AAAA, 16'h0, z, 0, z,
        2'b00, 0, 0, 16'h0, z, 2'b00, z, cf);
    add(0, 4'b0010, 16'h0040, z, 16'h0, z, 0, z,
        2'b01, 0, 1, 16'h0040, z, 2'b00, z, cf);
    add(0, 4'b0010, 16'h0040, z, 16'h0, z, 1, 32'h9999_9999,
        2'b00, 0, 0, 16'h0, z, 2'b00, z, cf);
    add(0, 4'b0000, 16'h0, z, 16'h0, z, 1, bd,
        2'b00, 0, 0, 16'h0, z, 2'b01, bd, cf);
    add(0, 4'b1000, 16'h0, z, 16'h0050, z, 0, z,
        2'b10, 0, 1, 16'h0050, z, 2'b00, bd, cf);
    add(0, 4'b1000, 16'h0, z, 16'h0050, z, 0, z,
        2'b00, 0, 0, 16'h0, z, 2'b00, bd, cf);
    add(1, 4'b0000, 16'h0, z, 16'h0, z, 0, z,
        2'b00, 0, 0, 16'h0, z, 2'b00, z, z);
    add(0, 4'b0000, 16'h0, z, 16'h0, z, 1, 32'h1212_1212,
        2'b00, 0, 0, 16'h0, z, 2'b00, z, z);
    add(0, 4'b0101, 16'h0070, 32'h7777_7777,
        16'h0080, 32'h8888_8888, 0, z,
        2'b01, 1, 0, 16'h0070, 32'h7777_7777, 2'b00, z, z);
    add(0, 4'b0000, 16'h0, z, 16'h0, z, 0, z,
        2'b00, 0, 0, 16'h0, z, 2'b00, z, z);

    foreach (vq[i]) begin
      rst = vq[i].r;
      m0_wr = vq[i].req[0]; m0_rd = vq[i].req[1];
      m1_wr = vq[i].req[2]; m1_rd = vq[i].req[3];
      m0_addr = vq[i].a0; m0_wdata = vq[i].d0;
      m1_addr = vq[i].a1; m1_wdata = vq[i].d1;
      rd_dvalid = vq[i].dv; rd_datain = vq[i].din;
      @(posedge clk);
      #1;
      act_v = {8'h0, m1_ready, m0_ready, wr_en, rd_en,
               wr_rd_addr, wr_data, m1_rvalid, m0_rvalid,
               m1_err, m0_err, m0_rdata, m1_rdata};
      exp_v = {8'h0, vq[i].rdy, vq[i].wen, vq[i].ren,
               vq[i].addr, vq[i].wd, vq[i].rv, 2'b00,
               vq[i].rd0, vq[i].rd1};
      chk($sformatf("vec%0d", i), act_v, exp_v);
    end

    // Read with a silent register bank
    idle_in();
    m0_rd = 1'b1; m0_addr = 16'h0060;
    @(posedge clk); #1;
    chk("rd_cmd", {m0_ready, rd_en, wr_rd_addr},
        {1'b1, 1'b1, 16'h0060});
    m0_rd = 1'b0;
    @(posedge clk); #1;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (m0_rvalid) begin
        n = i;
        break;
      end
    end
`ifdef RD_TIMEOUT_EN
    chk("to_latency", 128'(n), 128'd8);
    chk("to_resp", {m0_err, m0_rdata, m1_rvalid, m1_err},
        {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0});
    // Data arriving on the final timeout cycle still completes normally
    m0_rd = 1'b1; m0_addr = 16'h0064;
    @(posedge clk); #1;
    m0_rd = 1'b0;
    @(posedge clk); #1;
    early = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
      early = early | m0_rvalid;
    end
    chk("to_no_early", 128'(early), 128'd0);
    rd_dvalid = 1'b1; rd_datain = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    rd_dvalid = 1'b0;
    chk("to_race", {m0_rvalid, m0_err, m0_rdata},
        {1'b1, 1'b0, 32'h0F0F_0F0F});
`else
    chk("wait_forever", 128'(n), 128'd0);
    rd_dvalid = 1'b1; rd_datain = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    rd_dvalid = 1'b0;
    chk("late_resp", {m0_rvalid, m0_err, m0_rdata, m1_rvalid},
        {1'b1, 1'b0, 32'h0F0F_0F0F, 1'b0});
`endif
    @(posedge clk); #1;
    chk("rv_pulse", {m0_rvalid, m1_rvalid}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
